// File: rtl/audio_event_scheduler_pkg.sv
// Shared state encodings, event indices and the event-to-melody table for the scheduler.
package audio_sched_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int unsigned EV_GAME_LOST = 0;
  localparam int unsigned EV_HIT       = 1;
  localparam int unsigned EV_JEWEL     = 2;
  localparam int unsigned EV_OBJECTIVE = 3;
  localparam int unsigned EV_POWERUP   = 4;
  localparam int unsigned EV_MENU      = 5;

  localparam logic [3:0] EVENT_MELODY [8] = '{4'd12, 4'd11, 4'd14, 4'd15,
                                              4'd13, 4'd10, 4'd0, 4'd0};

  // Events beyond the table (spare lines) map to the silent melody 0.
  function automatic logic [3:0] event_melody(input int unsigned idx);
    return (idx < 32'd8) ? EVENT_MELODY[idx[2:0]] : 4'd0;
  endfunction

endpackage

// File: rtl/audio_event_scheduler_if.sv
// Event/melody-player handshake bundle between game logic, player and scheduler.
interface audio_event_scheduler_if #(
  parameter int unsigned NUM_EVENTS = 8
);
  localparam int unsigned IW = $clog2(NUM_EVENTS);

  logic [NUM_EVENTS-1:0] event_req;
  logic                  mute;
  logic                  rearm;
  logic                  melodyEnded;
  logic                  startMelodyKey;
  logic [3:0]            melody_select;
  logic                  busy;
  logic [IW-1:0]         active_event;
  logic                  timeout_pulse;

  modport master (
    output event_req, mute, rearm, melodyEnded,
    input  startMelodyKey, melody_select, busy, active_event, timeout_pulse
  );

  modport slave (
    input  event_req, mute, rearm, melodyEnded,
    output startMelodyKey, melody_select, busy, active_event, timeout_pulse
  );
endinterface

// File: rtl/audio_event_scheduler_prio_encoder.sv
// Lowest-set-bit finder: index 0 wins; o_valid flags a non-empty request vector.
module prio_encoder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         i_req,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_valid
);
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = ($clog2(N))'(i);
        o_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/audio_event_scheduler.sv
// Latches game event pulses and sequences them onto the single melody player by priority.
module audio_event_scheduler
  import audio_sched_pkg::*;
#(
  parameter int unsigned           NUM_EVENTS     = 8,
  parameter int unsigned           GAP_CYCLES     = 2,
  parameter int unsigned           TIMEOUT_CYCLES = 100_000_000,
  parameter logic [NUM_EVENTS-1:0] PREEMPT_MASK   = 8'b0000_0011,
  parameter logic [NUM_EVENTS-1:0] ONESHOT_MASK   = 8'b0000_1000
) (
  input logic                     clk,
  input logic                     resetN,
  audio_event_scheduler_if.slave  bus
);
  localparam int unsigned IW   = $clog2(NUM_EVENTS);
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [1:0]            r_state;
  logic [NUM_EVENTS-1:0] r_pending, r_played;
  logic [WD_W-1:0]       r_watchdog;
  logic [GW-1:0]         r_gap;
  logic                  r_start, r_timeout;
  logic [3:0]            r_sel;
  logic [IW-1:0]         r_active;

  logic [1:0]            w_next_state;
  logic [NUM_EVENTS-1:0] w_accept, w_issue_oh, w_pending_d, w_played_d;
  logic [IW-1:0]         w_widx, w_pidx, w_issue_idx;
  logic                  w_wvalid, w_pvalid, w_issue, w_timeout, w_wd_hit, w_gap_done;

  prio_encoder #(.N(NUM_EVENTS)) u_winner (
    .i_req   (r_pending),
    .o_idx   (w_widx),
    .o_valid (w_wvalid)
  );

  prio_encoder #(.N(NUM_EVENTS)) u_preempt (
    .i_req   (r_pending & PREEMPT_MASK),
    .o_idx   (w_pidx),
    .o_valid (w_pvalid)
  );

  assign w_wd_hit   = (r_watchdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign w_gap_done = ((32'(r_gap) + 32'd1) >= GAP_CYCLES);

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_issue_idx  = w_widx;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_wvalid && !bus.mute) begin
          w_issue      = 1'b1;
          w_next_state = S_PLAY;
        end
      end
      S_PLAY: begin
        // The start-pulse cycle makes no decisions, so starts are at least two cycles apart.
        if (!r_start) begin
          if (bus.melodyEnded) begin
            w_next_state = S_GAP;
          end else if (w_wd_hit) begin
            w_next_state = S_GAP;
            w_timeout    = 1'b1;
          end else if (w_pvalid && (w_pidx < r_active) && !bus.mute) begin
            w_issue     = 1'b1;
            w_issue_idx = w_pidx;
          end
        end
      end
      S_GAP: begin
        if (w_gap_done) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_issue_oh = w_issue ? (NUM_EVENTS'(1) << w_issue_idx) : '0;
    // Rearm in the same cycle lets a one-shot request through.
    w_accept   = bus.event_req & ~(ONESHOT_MASK & r_played & ~{NUM_EVENTS{bus.rearm}});
    w_pending_d = bus.mute ? '0 : ((r_pending | w_accept) & ~w_issue_oh);
    w_played_d  = (bus.rearm ? '0 : r_played) | (w_issue_oh & ONESHOT_MASK);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_played   <= '0;
      r_watchdog <= '0;
      r_gap      <= '0;
      r_start    <= 1'b0;
      r_timeout  <= 1'b0;
      r_sel      <= 4'd0;
      r_active   <= '0;
    end else begin
      r_state   <= w_next_state;
      r_pending <= w_pending_d;
      r_played  <= w_played_d;
      r_start   <= w_issue;
      r_timeout <= w_timeout;
      if (w_issue) begin
        r_sel      <= event_melody(32'(w_issue_idx));
        r_active   <= w_issue_idx;
        r_watchdog <= '0;
      end else if (r_state == S_PLAY && r_watchdog != '1) begin
        r_watchdog <= r_watchdog + 1'b1;
      end
      if (r_state == S_GAP) r_gap <= r_gap + 1'b1;
      else                  r_gap <= '0;
    end
  end

  assign bus.startMelodyKey = r_start;
  assign bus.melody_select  = r_sel;
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.active_event   = r_active;
  assign bus.timeout_pulse  = r_timeout;

endmodule

// File: tb/tb_audio_event_scheduler.sv
// Directed bench: a per-cycle vector table plus hand sequences for one-shot, timeout, mute, reset.
module tb_audio_event_scheduler;
  import audio_sched_pkg::*;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  audio_event_scheduler_if #(.NUM_EVENTS(8)) bus ();

  audio_event_scheduler #(.TIMEOUT_CYCLES(16)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0] req;
    logic       ended;
    logic       st;
    logic [3:0] sel;
    logic       bz;
    logic [2:0] act;
  } vec_t;

  vec_t tbl[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  function automatic logic [9:0] outs();
    return {bus.startMelodyKey, bus.melody_select, bus.busy, bus.active_event, bus.timeout_pulse};
  endfunction

  task automatic wait_start(input string name, input int budget);
    int n = 0;
    while (!bus.startMelodyKey && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(bus.startMelodyKey), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(bus.busy), 32'd0);
  endtask

  task automatic no_start(input string name, input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin
      tick();
      if (bus.startMelodyKey) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  task automatic pulse_req(input logic [7:0] r);
    bus.event_req = r;
    tick();
    bus.event_req = 8'h00;
  endtask

  task automatic end_melody();
    tick();
    bus.melodyEnded = 1'b1;
    tick();
    bus.melodyEnded = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    bus.event_req   = 8'h00;
    bus.mute        = 1'b0;
    bus.rearm       = 1'b0;
    bus.melodyEnded = 1'b0;

    // Row k: inputs held for one cycle, outputs expected right after that cycle's edge.
    tbl.push_back('{8'h10, 1'b0, 1'b0, 4'd0,  1'b0, 3'd0});
    tbl.push_back('{8'h00, 1'b0, 1'b1, 4'd13, 1'b1, 3'd4});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 4'd13, 1'b1, 3'd4});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 4'd13, 1'b1, 3'd4});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 4'd13, 1'b1, 3'd4});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 4'd13, 1'b0, 3'd4});
    tbl.push_back('{8'h30, 1'b0, 1'b0, 4'd13, 1'b0, 3'd4});
    tbl.push_back('{8'h00, 1'b0, 1'b1, 4'd13, 1'b1, 3'd4});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 4'd13, 1'b1, 3'd4});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 4'd13, 1'b1, 3'd4});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 4'd13, 1'b1, 3'd4});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 4'd13, 1'b0, 3'd4});
    tbl.push_back('{8'h00, 1'b0, 1'b1, 4'd10, 1'b1, 3'd5});
    tbl.push_back('{8'h02, 1'b0, 1'b0, 4'd10, 1'b1, 3'd5});
    tbl.push_back('{8'h00, 1'b0, 1'b1, 4'd11, 1'b1, 3'd1});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 4'd11, 1'b1, 3'd1});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 4'd11, 1'b1, 3'd1});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 4'd11, 1'b1, 3'd1});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 4'd11, 1'b0, 3'd1});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 4'd11, 1'b0, 3'd1});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 4'd11, 1'b0, 3'd1});
    tbl.push_back('{8'h10, 1'b0, 1'b0, 4'd11, 1'b0, 3'd1});
    tbl.push_back('{8'h00, 1'b0, 1'b1, 4'd13, 1'b1, 3'd4});
    tbl.push_back('{8'h01, 1'b0, 1'b0, 4'd13, 1'b1, 3'd4});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 4'd13, 1'b1, 3'd4});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 4'd13, 1'b1, 3'd4});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 4'd13, 1'b0, 3'd4});
    tbl.push_back('{8'h00, 1'b0, 1'b1, 4'd12, 1'b1, 3'd0});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 4'd12, 1'b1, 3'd0});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 4'd12, 1'b1, 3'd0});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 4'd12, 1'b1, 3'd0});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 4'd12, 1'b0, 3'd0});

    repeat (3) tick();
    check("reset outputs", 32'(outs()), 32'd0);
    resetN = 1'b1;
    tick();
    check("idle after reset", 32'(outs()), 32'd0);

    foreach (tbl[i]) begin
      bus.event_req   = tbl[i].req;
      bus.melodyEnded = tbl[i].ended;
      tick();
      check($sformatf("vec %0d", i), 32'(outs()),
            32'({tbl[i].st, tbl[i].sel, tbl[i].bz, tbl[i].act, 1'b0}));
    end
    bus.event_req   = 8'h00;
    bus.melodyEnded = 1'b0;

    // One-shot objective: plays once, blocked until rearm, rearm+request together accepted.
    pulse_req(8'h1 << EV_OBJECTIVE);
    wait_start("os first start", 4);
    check("os first sel", 32'(bus.melody_select), 32'd15);
    end_melody();
    wait_idle("os first idle", 10);
    pulse_req(8'h08);
    no_start("os blocked", 8);
    bus.rearm = 1'b1;
    tick();
    bus.rearm = 1'b0;
    pulse_req(8'h08);
    wait_start("os rearmed start", 4);
    check("os rearmed sel", 32'(bus.melody_select), 32'd15);
    end_melody();
    wait_idle("os rearmed idle", 10);
    bus.rearm = 1'b1;
    pulse_req(8'h08);
    bus.rearm = 1'b0;
    wait_start("os rearm same cycle", 4);
    end_melody();
    wait_idle("os same idle", 10);

    // Same-cycle request on the index being issued is absorbed.
    pulse_req(8'h10);
    bus.event_req = 8'h10;
    tick();
    bus.event_req = 8'h00;
    check("absorb start", 32'(bus.startMelodyKey), 32'd1);
    end_melody();
    wait_idle("absorb idle", 10);
    no_start("absorb no replay", 6);

    // Watchdog forces an end exactly TIMEOUT_CYCLES after the start pulse.
    pulse_req(8'h1 << EV_POWERUP);
    wait_start("to start", 4);
    cnt = 0;
    while (!bus.timeout_pulse && cnt < 40) begin
      tick();
      cnt++;
    end
    check("to latency", 32'(cnt), 32'd16);
    tick();
    check("to one cycle", 32'(bus.timeout_pulse), 32'd0);
    check("to gap busy", 32'(bus.busy), 32'd1);
    tick();
    check("to back idle", 32'(bus.busy), 32'd0);

    // Mute drops pending events but lets the current melody finish.
    pulse_req(8'h10);
    wait_start("mute start", 4);
    tick();
    pulse_req(8'h14);
    bus.mute = 1'b1;
    tick();
    check("mute keeps playing", 32'(bus.busy), 32'd1);
    bus.melodyEnded = 1'b1;
    tick();
    bus.melodyEnded = 1'b0;
    no_start("muted no start", 8);
    check("muted idle", 32'(bus.busy), 32'd0);
    bus.mute = 1'b0;
    no_start("unmuted stays idle", 8);

    // Reset in mid-melody: everything zero next cycle, nothing replays.
    pulse_req(8'h10);
    wait_start("rst start", 4);
    tick();
    tick();
    resetN = 1'b0;
    tick();
    check("rst mid play", 32'(outs()), 32'd0);
    resetN = 1'b1;
    no_start("rst no replay", 6);
    check("rst idle", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/audio_event_scheduler.md
Name: audio_event_scheduler

Overview:
- Arbitrates and sequences sound-effect requests from game logic onto the single melody player (startMelodyKey / melody_select / melodyEnded handshake).
- Sits between gameplay event sources (power-ups, hits, objective, game-over, menu) and the melody player.
- Latches one-cycle event pulses so none are lost while a melody plays, issues them by fixed priority, and lets urgent events preempt.
- Enforces an inter-melody gap, a watchdog timeout and one-shot events.

Parameters:
- NUM_EVENTS, 8, number of event request lines; index 0 is highest priority.
- GAP_CYCLES, 2, idle cycles inserted after a melody ends, before the next start.
- TIMEOUT_CYCLES, 100_000_000, maximum PLAY duration (2 s at 50 MHz) before forced end.
- PREEMPT_MASK, 8'b0000_0011, bit i set: event i may interrupt a lower-priority melody.
- ONESHOT_MASK, 8'b0000_1000, bit i set: event i plays at most once until rearm.

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous active-low reset, sampled on posedge clk.
- event_req  in  NUM_EVENTS  one-cycle request pulses, one bit per event.
- mute  in  1  drops new requests and pending events; no new starts.
- rearm  in  1  one-cycle pulse; re-enables all one-shot events.
- melodyEnded  in  1  player end-of-melody pulse.
- startMelodyKey  out  1  one-cycle start pulse to the player.
- melody_select  out  4  melody id; valid on the start pulse and held until the next start.
- busy  out  1  high in PLAY and GAP.
- active_event  out  $clog2(NUM_EVENTS)  index of the event currently playing.
- timeout_pulse  out  1  one-cycle pulse when the watchdog forces an end.

Behaviour:
- Reset (resetN=0 at posedge):
  - state=S_IDLE; pending=0; played=0; counters=0.
  - All outputs 0.
  - A reset in mid-melody abandons it silently; no start pulse is issued.
- pending[i] is set on event_req[i] unless mute=1, or (ONESHOT_MASK[i] and played[i]).
- pending[i] is cleared in the cycle event i is issued.
- A request arriving in the same cycle its own index is issued is absorbed, not re-queued.
- mute=1 clears all pending every cycle. A melody already playing runs to completion.
- winner = lowest set index of pending. All outputs are registered.
- S_IDLE:
  - If pending≠0 and !mute: next cycle startMelodyKey=1, melody_select=EVENT_MELODY[winner], active_event=winner, played[winner]=1 if one-shot. Go to S_PLAY, watchdog=0.
- S_PLAY:
  - startMelodyKey=0 after the first cycle.
  - melodyEnded is ignored in the first PLAY cycle (the start-pulse cycle).
  - Priority within a cycle: melodyEnded > timeout > preempt.
  - melodyEnded: go to S_GAP, gap counter=0.
  - Watchdog reaches TIMEOUT_CYCLES-1: timeout_pulse=1, go to S_GAP.
  - Preempt: pending winner j < active_event and PREEMPT_MASK[j]. Next cycle issues a start pulse for j and stays in S_PLAY with watchdog=0. The interrupted event is dropped, not re-queued.
  - If melodyEnded and a preempt occur together, go to S_GAP; j stays pending.
- S_GAP:
  - Count GAP_CYCLES, then go to S_IDLE.
  - With GAP_CYCLES=0, go to S_IDLE on the next cycle.
  - busy=1.
- rearm clears played[] in any state. rearm and a one-shot request in the same cycle: the request is accepted.
- Minimum start-to-start spacing is GAP_CYCLES+3 cycles without preemption, and 2 cycles with preemption.
- Watchdog width is $clog2(TIMEOUT_CYCLES). It saturates and never wraps.

Decomposition:
- Package audio_sched_pkg holds:
  - state enum {S_IDLE, S_PLAY, S_GAP};
  - event index constants: EV_GAME_LOST=0, EV_HIT=1, EV_JEWEL=2, EV_OBJECTIVE=3, EV_POWERUP=4, EV_MENU=5, spare 6–7;
  - EVENT_MELODY table (4-bit ids: 12, 11, 14, 15, 13, 10, 0, 0).
- One sub-module, prio_encoder: lowest-set-bit finder returning index and valid. It is reused for both winner and preempt checks.

Test Plan:
- Reset then event_req=8'h10 for one cycle -> startMelodyKey pulses 2 cycles later, melody_select=13, active_event=4, busy=1; melodyEnded -> busy falls after GAP_CYCLES+1 cycles.
- event_req bits 4 and 5 in the same cycle -> melody 13 starts; after end+gap, melody 10 starts with no second request.
- Melody 10 (event 5) playing, event_req[1] pulse -> start pulse 2 cycles later with melody_select=11; event 5 does not replay after the end.
- event_req[3] twice with melodyEnded between, then rearm, then event_req[3] -> first plays, second ignored, third plays melody 15.
- Start event 4 and never assert melodyEnded -> timeout_pulse exactly TIMEOUT_CYCLES cycles after the start pulse (override TIMEOUT_CYCLES=16), then S_IDLE.
- mute=1 with events 2 and 4 pending mid-melody -> no further start pulses; releasing mute with no new requests -> stays idle. Also: resetN=0 mid-PLAY -> all outputs 0 next cycle.
